// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
// Shared ISA definitions for the fetch unit and the instruction register:
// opcode encodings, fetch FSM states and the per-opcode busy-cycle table.
// Both ends of the instruction byte bus take their timing from
// op_busy_cycles(), so the issue spacing and the register's idle window
// always agree.
package cpu_isa_pkg;

  localparam int OPCODE_W = 3;
  localparam int BUSY_W   = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    ISSUE,
    EXEC,
    HALTED
  } fetch_state_t;

  // Number of cycles the instruction register stays busy after an issue.
  function automatic logic [BUSY_W-1:0] op_busy_cycles(input opcode_t op);
    case (op)
      OP_HLT:  return 3'd0;
      OP_SKZ:  return 3'd2;
      OP_JMP:  return 3'd3;
      OP_STO:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetches one instruction byte per instruction from program memory over a
// req/valid handshake, presents it on ir_data for one cycle, then holds the
// bus at zero for the opcode's busy window. Owns the program counter and
// resolves HLT, SKZ and JMP.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_req, mem_addr   read request and address to program memory
//   mem_valid, mem_rdata read response; only accepted while mem_req=1
//   ir_data, ir_issue   instruction byte and its one-cycle issue strobe
//   zero                accumulator-zero flag used by SKZ
//   go                  resume pulse, honoured only while halted
//   halted              high while stopped on HLT
//   pc                  current program counter
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_issue,
  input  logic              zero,
  input  logic              go,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state;
  logic [BUSY_W-1:0] busy_cnt;
  logic [DATA_W-1:0] instr;
  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = opcode_t'(instr[DATA_W-1 -: OPCODE_W]);
  assign operand = instr[ADDR_W-1:0];

  // Program counter update; additions wrap naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] next_pc(input opcode_t           op,
                                                input logic [ADDR_W-1:0] cur,
                                                input logic [ADDR_W-1:0] target,
                                                input logic              z);
    case (op)
      OP_JMP:  return target;
      OP_SKZ:  return z ? cur + ADDR_W'(2) : cur + ADDR_W'(1);
      default: return cur + ADDR_W'(1);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir_data  <= '0;
      ir_issue <= 1'b0;
      halted   <= 1'b0;
      busy_cnt <= '0;
      instr    <= '0;
    end else begin
      case (state)
        FETCH: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= WAIT;
        end
        WAIT: begin
          // Byte goes straight to ir_data so it is on the bus during ISSUE.
          if (mem_valid) begin
            instr    <= mem_rdata;
            ir_data  <= mem_rdata;
            ir_issue <= 1'b1;
            mem_req  <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          ir_data  <= '0;
          ir_issue <= 1'b0;
          busy_cnt <= op_busy_cycles(opcode);
          if (op_busy_cycles(opcode) != '0) begin
            state <= EXEC;
          end else begin
            // Only HLT has an empty busy window.
            pc     <= next_pc(opcode, pc, operand, zero);
            halted <= 1'b1;
            state  <= HALTED;
          end
        end
        EXEC: begin
          // zero is sampled in the final busy cycle, after the register
          // has had the whole window to settle the accumulator.
          busy_cnt <= busy_cnt - BUSY_W'(1);
          if (busy_cnt == BUSY_W'(1)) begin
            pc    <= next_pc(opcode, pc, operand, zero);
            state <= FETCH;
          end
        end
        HALTED: begin
          if (go) begin
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic       clk, rst_n, mem_req, mem_valid, ir_issue, zero, go, halted;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_rdata, ir_data;

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .ir_data(ir_data),
    .ir_issue(ir_issue), .zero(zero), .go(go), .halted(halted), .pc(pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory with a configurable response latency; "spurious" forces
  // mem_valid high regardless of mem_req.
  logic [7:0] mem [32];
  int         lat;
  logic       spurious;

  initial begin
    int cnt;
    cnt       = 0;
    mem_valid = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (spurious) begin
        mem_valid = 1'b1;
        mem_rdata = 8'hFF;
        cnt       = 0;
      end else if (mem_req) begin
        mem_valid = (cnt >= lat);
        mem_rdata = (cnt >= lat) ? mem[mem_addr] : 8'h00;
        cnt++;
      end else begin
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        cnt       = 0;
      end
    end
  end

  // Hand-computed pins for each run, set by the stimulus while in reset.
  int pin_first_byte, pin_first_cyc, pin_second_cyc, pin_len;
  int pin_addr [16];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int busy_of(input logic [2:0] op);
    case (op)
      3'b000:  return 0;
      3'b001:  return 2;
      3'b111:  return 3;
      3'b110:  return 4;
      default: return 5;
    endcase
  endfunction

  // Behavioural model: tracks the architectural pc and, per instruction,
  // the expected sequence request -> issue -> N bubbles -> 1 idle cycle.
  int         m_pc, m_gap, m_bub, cyc, issue_no, pin_idx;
  logic       m_issue, m_halt, m_halt_new, m_req_prev;
  logic [7:0] m_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_req",  32'(mem_req),  0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_ir_data",  32'(ir_data),  0);
      chk("rst_ir_issue", 32'(ir_issue), 0);
      chk("rst_halted",   32'(halted),   0);
      chk("rst_pc",       32'(pc),       0);
      m_pc = 0; m_gap = 1; m_bub = 0; cyc = 0; issue_no = 0; pin_idx = 0;
      m_issue = 1'b0; m_halt = 1'b0; m_halt_new = 1'b0; m_req_prev = 1'b0;
      m_byte = 8'h00;
    end else begin
      cyc++;
      if (m_issue) begin
        chk("issue_strobe", 32'(ir_issue), 1);
        chk("issue_data",   32'(ir_data),  32'(m_byte));
        chk("issue_req",    32'(mem_req),  0);
        issue_no++;
        if (issue_no == 1) begin
          chk("pin_first_byte", 32'(ir_data), pin_first_byte);
          chk("pin_first_cyc",  cyc,          pin_first_cyc);
        end
        if (issue_no == 2 && pin_second_cyc != 0)
          chk("pin_second_cyc", cyc, pin_second_cyc);
        m_issue = 1'b0;
        m_bub   = busy_of(m_byte[7:5]);
        if (m_bub == 0) begin
          m_pc       = (m_pc + 1) % 32;
          m_halt     = 1'b1;
          m_halt_new = 1'b1;
        end
      end else if (m_bub > 0) begin
        chk("bubble_data",   32'(ir_data),  0);
        chk("bubble_issue",  32'(ir_issue), 0);
        chk("bubble_req",    32'(mem_req),  0);
        chk("bubble_halted", 32'(halted),   0);
        if (m_bub == 1) begin
          case (m_byte[7:5])
            3'b111:  m_pc = int'(m_byte[4:0]);
            3'b001:  m_pc = (m_pc + (zero ? 2 : 1)) % 32;
            default: m_pc = (m_pc + 1) % 32;
          endcase
          m_gap = 1;
        end
        m_bub--;
      end else if (m_gap > 0) begin
        chk("idle_req",   32'(mem_req),  0);
        chk("idle_data",  32'(ir_data),  0);
        chk("idle_issue", 32'(ir_issue), 0);
        chk("idle_halt",  32'(halted),   0);
        m_gap--;
      end else if (m_halt) begin
        chk("halt_flag",  32'(halted),   1);
        chk("halt_req",   32'(mem_req),  0);
        chk("halt_data",  32'(ir_data),  0);
        chk("halt_issue", 32'(ir_issue), 0);
        chk("halt_pc",    32'(pc),       m_pc);
        if (m_halt_new) begin
          chk("pin_halt_pc", 32'(pc), 8);
          m_halt_new = 1'b0;
        end
        if (go) begin
          m_halt = 1'b0;
          m_gap  = 1;
        end
      end else begin
        chk("req",        32'(mem_req),  1);
        chk("req_addr",   32'(mem_addr), m_pc);
        chk("req_pc",     32'(pc),       m_pc);
        chk("req_data",   32'(ir_data),  0);
        chk("req_issue",  32'(ir_issue), 0);
        chk("req_halted", 32'(halted),   0);
        if (!m_req_prev && pin_idx < pin_len) begin
          chk("pin_fetch_addr", 32'(mem_addr), pin_addr[pin_idx]);
          pin_idx++;
        end
        m_req_prev = 1'b1;
        if (mem_valid) begin
          m_issue    = 1'b1;
          m_byte     = mem[m_pc[4:0]];
          m_req_prev = 1'b0;
        end
      end
    end
  end

  task automatic wait_req(input int a, input int limit);
    int n = 0;
    while (!(mem_req && int'(mem_addr) == a)) begin
      @(posedge clk); #1;
      n++;
      if (n > limit) begin
        $display("FAIL wait_req: addr %0d not requested within %0d cycles", a, limit);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic wait_flag(input string name, input int which, input int limit);
    int n = 0;
    while (!((which == 0) ? ir_issue : halted)) begin
      @(posedge clk); #1;
      n++;
      if (n > limit) begin
        $display("FAIL wait_%s: not seen within %0d cycles", name, limit);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0 | 8'(i);
  endtask

  initial begin
    rst_n = 1'b1; zero = 1'b1; go = 1'b0; lat = 0; spurious = 1'b0;
    fill_mem();
    // Run 1: ADD, LDA, STO, JMP 10, JMP 4, SKZ x2, JMP 7, HLT, JMP 8 (self).
    mem[0] = 8'h45; mem[1] = 8'hA0; mem[2] = 8'hC1; mem[3] = 8'hEA;
    mem[10] = 8'hE4; mem[4] = 8'h20; mem[6] = 8'hE4; mem[5] = 8'hE7;
    mem[7] = 8'h00; mem[8] = 8'hE8;
    pin_first_byte = 8'h45; pin_first_cyc = 3; pin_second_cyc = 11;
    pin_addr = '{0, 1, 2, 3, 10, 4, 6, 4, 5, 7, 8, 8, 0, 0, 0, 0};
    pin_len  = 12;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_flag("issue", 0, 50);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    wait_req(6, 300);
    zero = 1'b0;
    wait_flag("halted", 1, 300);
    repeat (20) @(posedge clk);
    #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    wait_req(8, 50);
    repeat (30) @(posedge clk);
    #1;

    // Run 2: 4-cycle memory latency, SKZ at 30 and STO at 31 wrapping to 0.
    rst_n = 1'b0; zero = 1'b0; lat = 4;
    fill_mem();
    mem[0] = 8'hFE; mem[30] = 8'h20; mem[31] = 8'hC2;
    pin_first_byte = 8'hFE; pin_first_cyc = 7; pin_second_cyc = 0;
    pin_addr = '{0, 30, 31, 0, 30, 0, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pin_len  = 8;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_req(31, 400);
    zero = 1'b1;
    wait_req(30, 400);
    repeat (2) @(posedge clk);
    // Abort mid-wait; a late response must not be taken.
    #1 rst_n = 1'b0; spurious = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Run 3: restart after the abort with single-cycle memory.
    lat = 0;
    pin_first_byte = 8'hFE; pin_first_cyc = 3; pin_second_cyc = 0;
    pin_addr = '{0, 30, 0, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pin_len  = 5;
    rst_n = 1'b1;
    @(posedge clk); #1 spurious = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
